// File: rtl/ahb_bus_arbiter.sv
// Three-master AHB arbiter: m0 fixed priority over a round-robin pair (m1, m2),
// non-preemptive ownership, and a drain cycle between grants.
module ahb_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                hreset_n,
  input  logic [2:0]          m_req,
  output logic [2:0]          m_ack,
  input  logic [3*ADDR_W-1:0] m_haddr,
  input  logic [2:0]          m_hwrite,
  input  logic [8:0]          m_hsize,
  input  logic [8:0]          m_hburst,
  input  logic [11:0]         m_hprot,
  input  logic [5:0]          m_htrans,
  input  logic [2:0]          m_hmastlock,
  input  logic [3*DATA_W-1:0] m_hwdata,
  output logic [2:0]          m_hready,
  output logic [2:0]          m_hresp,
  output logic [DATA_W-1:0]   m_hrdata,
  output logic [ADDR_W-1:0]   haddr,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [3:0]          hprot,
  output logic [1:0]          htrans,
  output logic                hmastlock,
  output logic [DATA_W-1:0]   hwdata,
  input  logic                hready,
  input  logic                hresp,
  input  logic [DATA_W-1:0]   hrdata
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_OWN       = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;
  localparam logic [1:0] OWNER_NONE  = 2'd3;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [1:0] state, state_nxt;
  logic [1:0] aowner, aowner_nxt;
  logic [1:0] downer, downer_nxt;
  logic       rr_ptr, rr_ptr_nxt;   // 0: m1 is next in the pair, 1: m2
  logic [2:0] m_ack_nxt;
  logic [1:0] grant;

  logic              sel_req;
  logic [ADDR_W-1:0] sel_haddr;
  logic              sel_hwrite;
  logic [2:0]        sel_hsize;
  logic [2:0]        sel_hburst;
  logic [3:0]        sel_hprot;
  logic [1:0]        sel_htrans;
  logic              sel_hmastlock;

  // Pick the address-phase owner's request and control slices
  always_comb begin
    sel_req       = 1'b0;
    sel_haddr     = '0;
    sel_hwrite    = 1'b0;
    sel_hsize     = 3'd0;
    sel_hburst    = 3'd0;
    sel_hprot     = 4'd0;
    sel_htrans    = HTRANS_IDLE;
    sel_hmastlock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (aowner == 2'(i)) begin
        sel_req       = m_req[i];
        sel_haddr     = m_haddr[i*ADDR_W +: ADDR_W];
        sel_hwrite    = m_hwrite[i];
        sel_hsize     = m_hsize[i*3 +: 3];
        sel_hburst    = m_hburst[i*3 +: 3];
        sel_hprot     = m_hprot[i*4 +: 4];
        sel_htrans    = m_htrans[i*2 +: 2];
        sel_hmastlock = m_hmastlock[i];
      end
    end
  end

  // Shared address/control: owner's slices in OWN, safe idle values otherwise
  always_comb begin
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = 3'd0;
    hburst    = 3'd0;
    hprot     = 4'b0011;
    htrans    = HTRANS_IDLE;
    hmastlock = 1'b0;
    if (state == S_OWN) begin
      haddr     = sel_haddr;
      hwrite    = sel_hwrite;
      hsize     = sel_hsize;
      hburst    = sel_hburst;
      hprot     = sel_hprot;
      htrans    = sel_htrans;
      hmastlock = sel_hmastlock;
    end
  end

  // Write data follows the data-phase owner
  always_comb begin
    hwdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (downer == 2'(i)) hwdata = m_hwdata[i*DATA_W +: DATA_W];
    end
  end

  // Gate hready/hresp to the address-phase owner (in OWN) and the data-phase owner
  always_comb begin
    m_hready = 3'b000;
    m_hresp  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if ((state == S_OWN && aowner == 2'(i)) || downer == 2'(i)) begin
        m_hready[i] = hready;
        m_hresp[i]  = hresp;
      end
    end
  end

  assign m_hrdata = hrdata;

  // Priority m0, then round-robin between m1 and m2
  always_comb begin
    grant = 2'd0;
    if (m_req[0])                grant = 2'd0;
    else if (m_req[1] && m_req[2]) grant = rr_ptr ? 2'd2 : 2'd1;
    else if (m_req[1])           grant = 2'd1;
    else if (m_req[2])           grant = 2'd2;
  end

  // Next-state, grant and data-phase owner logic
  always_comb begin
    state_nxt  = state;
    aowner_nxt = aowner;
    rr_ptr_nxt = rr_ptr;
    m_ack_nxt  = m_ack;
    downer_nxt = downer;
    case (state)
      S_IDLE: begin
        if (|m_req) begin
          state_nxt  = S_OWN;
          aowner_nxt = grant;
          m_ack_nxt  = 3'b001 << grant;
          if (grant != 2'd0) rr_ptr_nxt = (grant == 2'd1);
        end
      end
      S_OWN: begin
        if (!sel_req && sel_htrans == HTRANS_IDLE && !sel_hmastlock) begin
          state_nxt = S_DRAIN;
          m_ack_nxt = 3'b000;
        end
      end
      S_DRAIN: begin
        if (hready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        m_ack_nxt = 3'b000;
      end
    endcase
    if (hready) downer_nxt = (state == S_OWN && htrans[1]) ? aowner : OWNER_NONE;
  end

  // State and arbitration registers
  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state  <= S_IDLE;
      aowner <= 2'd0;
      downer <= OWNER_NONE;
      rr_ptr <= 1'b0;
      m_ack  <= 3'b000;
    end else begin
      state  <= state_nxt;
      aowner <= aowner_nxt;
      downer <= downer_nxt;
      rr_ptr <= rr_ptr_nxt;
      m_ack  <= m_ack_nxt;
    end
  end

endmodule
